// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: byte-wide UART serializer. Pops one byte per valid/ready
// handshake and shifts it out LSB-first as start, 8 data, optional parity
// and 1 or 2 stop bits. The bit period is divisor+1 clk cycles. Frame
// settings are latched when a byte is accepted.
module uart_tx #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   output logic                 tx,
   output logic                 busy
);

   localparam logic [DIV_WIDTH-1:0] TIMER_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state, state_nxt;
   logic [2:0]           bit_idx;
   logic                 stop_second, stop_second_nxt;
   logic                 tx_q, tx_nxt;
   logic                 busy_q;

   logic [DIV_WIDTH-1:0] timer;
   logic [DIV_WIDTH-1:0] div_q;
   logic [7:0]           shift;
   logic                 par_en_q;
   logic                 two_stop_q;
   logic                 par_bit;

   logic                 bit_end;
   logic                 last_stop;
   logic                 xfer;

   // The bit ends in the cycle the down-counting timer reads zero; the final
   // stop bit is the second one when two stop bits were latched.
   assign bit_end   = (timer == '0);
   assign last_stop = (state == STOP) && bit_end && (stop_second || !two_stop_q);
   assign in_ready  = (state == IDLE) || last_stop;
   // A byte presented while reset is asserted is never taken.
   assign xfer      = in_valid && in_ready && rst_n;

   assign tx   = tx_q;
   assign busy = busy_q;

   // Next-state logic plus the value tx will take in the next state.
   always_comb begin
      state_nxt       = state;
      stop_second_nxt = stop_second;
      tx_nxt          = 1'b1;

      unique case (state)
         IDLE: begin
            if (xfer) state_nxt = START;
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && (bit_idx == 3'd7)) state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (last_stop) state_nxt = xfer ? START : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Track whether the current stop bit is the second of two.
      if (state == STOP) begin
         if (bit_end) stop_second_nxt = !last_stop;
      end else begin
         stop_second_nxt = 1'b0;
      end

      // tx is computed one cycle early so the registered line is glitch-free.
      unique case (state_nxt)
         IDLE:    tx_nxt = 1'b1;
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = ((state == DATA) && bit_end) ? shift[1] : shift[0];
         PARITY:  tx_nxt = par_bit;
         STOP:    tx_nxt = 1'b1;
         default: tx_nxt = 1'b1;
      endcase
   end

   // Control state: FSM, bit index, stop-bit tracker and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bit_idx     <= 3'd0;
         stop_second <= 1'b0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         stop_second <= stop_second_nxt;
         tx_q        <= tx_nxt;
         busy_q      <= (state_nxt != IDLE);
         if (xfer) begin
            bit_idx <= 3'd0;
         end else if ((state == DATA) && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // Datapath: capture the byte and frame settings at the handshake, reload
   // the bit timer at each bit boundary, shift data as each data bit ends.
   always_ff @(posedge clk) begin
      if (xfer) begin
         shift      <= in_data;
         div_q      <= divisor;
         par_en_q   <= parity_en;
         two_stop_q <= two_stop;
         par_bit    <= (^in_data) ^ parity_odd;
         timer      <= divisor;
      end else if (bit_end) begin
         timer <= div_q;
         if (state == DATA) shift <= {1'b0, shift[7:1]};
      end else begin
         timer <= timer - TIMER_ONE;
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serializer that consumes bytes from the pop port of a transmit-side buffer and drives the serial TX line of the machine's console UART.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first as a full UART frame: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Bit timing comes from a runtime divisor supplied by the UART register block.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input and the internal bit-timer counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- in_valid  input  1  byte available (connected to the buffer pop_valid).
- in_ready  output  1  byte accepted this cycle when in_valid=1 (connected to the buffer pop_ready).
- in_data  input  8  byte to transmit (connected to the buffer pop_data).
- divisor  input  DIV_WIDTH  bit period minus one, in clk cycles.
- parity_en  input  1  1 = append a parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- two_stop  input  1  1 = two stop bits, 0 = one stop bit.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - State goes to IDLE; tx=1, busy=0, in_ready=1 from the next cycle.
  - Any frame in progress is aborted immediately; tx returns high with no partial stop bit.
- Handshake:
  - A transfer occurs on a clk edge where in_valid & in_ready.
  - in_ready is combinational: 1 in IDLE, or in the final cycle of the final stop bit. This allows back-to-back frames with no idle gap.
  - in_ready never depends on in_valid.
  - in_data must stay stable while in_valid=1 and in_ready=0. This is the buffer's guarantee and is not checked here.
- Capture at transfer:
  - Latch in_data into the shift register, and latch divisor, parity_en, parity_odd and two_stop.
  - Changes to these inputs mid-frame have no effect on the frame in progress.
  - Computed parity bit = XOR of the 8 data bits XOR parity_odd.
- Bit timing:
  - Every bit lasts latched_divisor+1 clk cycles; divisor=0 gives 1 cycle per bit.
  - The timer loads with the divisor at each bit start and counts down to 0; the bit ends in the cycle the timer reads 0.
- State machine (tx value per state):
  - IDLE (tx=1): on transfer, go to START.
  - START (tx=0): at bit end, go to DATA with bit index 0.
  - DATA (tx=shift[0]): at bit end, shift right and increment the index. After index 7 ends, go to PARITY if parity_en, else STOP.
  - PARITY (tx=parity bit): at bit end, go to STOP.
  - STOP (tx=1): lasts 1 bit, or 2 bits if two_stop. At the end of the final stop bit, go to START if a transfer occurs that same cycle, else IDLE.
- Latency and frame length:
  - tx is driven low in the cycle after the accepting edge.
  - Frame length in bit periods: 10, plus 1 with parity, plus 1 with two stop bits.
- busy: 1 in every state except IDLE, registered with the state.
- tx is a direct registered output (state/shift based) so the line is glitch-free.
- Corner cases:
  - Divisor at its maximum (all ones) must not overflow the timer.
  - in_valid asserting in the same cycle reset deasserts is ignored until in_ready=1 is sampled with rst_n=1.

Test Plan:
- Reset with divisor=3, no input → tx=1, busy=0, in_ready=1 held indefinitely.
- Send 0x55, divisor=3, no parity, 1 stop → tx low 1 cycle after accept; bit sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; 40 cycles total; busy=0 and in_ready=1 after.
- Send 0xA3, divisor=0, parity_en=1 with parity_odd=0, then repeat with parity_odd=1 → parity bit 0 (even) then 1 (odd); each frame 11 cycles; two_stop=1 extends to 12 cycles.
- Buffer holds 0x01, 0x02, 0x03 (in_valid held high), divisor=1 → three frames with no idle cycle between stop and start; exactly 3 handshakes; 60 cycles total.
- Change divisor from 1 to 7 mid-frame → current frame keeps 2-cycle bits; the next accepted byte uses 8-cycle bits.
- Assert rst_n=0 for 1 cycle during DATA bit 3 → next cycle tx=1, busy=0, in_ready=1; the next byte is sent as a complete, correct frame.
